// File: rtl/fetch_pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer_pkg
//   Shared definitions for the fetch PC sequencer:
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - default reset vector and sequential PC step
//   - canonical NOP encoding (addi x0, x0, 0)
//   - next-PC mux select type and a word-alignment helper
// ----------------------------------------------------------------------------
package fetch_pc_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_KILL = 2'd3;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP      = 32'd4;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  // Instructions are word aligned; redirect targets drop their low two bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_pc_reg.sv
// ----------------------------------------------------------------------------
// fetch_pc_reg
//   Program counter register with its next-PC mux.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (pc <= RESET_VECTOR)
//     sel          PC_HOLD keeps pc, PC_SEQ loads adder_sum,
//                  PC_REDIR loads redirect_pc with bits[1:0] cleared
//     adder_sum    sequential next PC from the external adder
//     redirect_pc  branch/jump target from execute
//     pc           current program counter
// ----------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel,
  input  logic [31:0] adder_sum,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else begin
      case (sel)
        PC_SEQ:   pc <= adder_sum;
        PC_REDIR: pc <= align_word(redirect_pc);
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer
//   PC / instruction-fetch sequencer sitting around an external 32-bit adder.
//   One outstanding fetch at a time; each fetched word is held for decode
//   until accepted, then the next fetch is issued.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     adder_in1/adder_in2        current PC and PC_STEP to the adder
//     adder_sum                  PC + PC_STEP from the adder (same cycle)
//     redirect_valid/redirect_pc branch/jump redirect from execute
//     stall                      hazard stall, blocks decode acceptance
//     imem_req/imem_addr         fetch request to instruction memory
//     imem_ack/imem_rdata        fetch completion and data
//     inst_valid/inst_out/inst_pc  instruction presented to decode
//     inst_ready                 decode ready (accept = valid & ready & !stall)
//     misalign_err               sticky: a redirect target was not word aligned
// ----------------------------------------------------------------------------
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] adder_in1,
  output logic [31:0] adder_in2,
  input  logic [31:0] adder_sum,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign_err
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] kill_pc;
  pc_sel_e     pc_sel;
  logic        capture;
  logic        accept;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (pc_sel),
    .adder_sum   (adder_sum),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  assign adder_in1 = pc;
  assign adder_in2 = PC_STEP;

  assign accept = inst_valid && inst_ready && !stall;

  // A killed fetch keeps presenting the address it was issued with, so the
  // memory sees a stable request until it acks the stale access.
  assign imem_req  = (state == ST_REQ) || (state == ST_KILL);
  assign imem_addr = (state == ST_KILL) ? kill_pc : pc;

  always_comb begin
    state_nxt = state;
    pc_sel    = PC_HOLD;
    capture   = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          state_nxt = ST_HOLD;
          pc_sel    = PC_SEQ;
          capture   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) state_nxt = ST_REQ;
      end
      ST_KILL: begin
        if (imem_ack) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Redirect overrides everything, including a same-cycle ack in REQ
    // (that data belongs to the wrong path and is dropped).
    if (redirect_valid) begin
      pc_sel  = PC_REDIR;
      capture = 1'b0;
      if (state == ST_KILL) begin
        state_nxt = imem_ack ? ST_REQ : ST_KILL;
      end else if ((state == ST_REQ) && !imem_ack) begin
        state_nxt = ST_KILL;
      end else begin
        state_nxt = ST_REQ;
      end
    end
  end

  // Stage boundary: FSM and stale-fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      kill_pc <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      if (redirect_valid && (state == ST_REQ) && !imem_ack) begin
        kill_pc <= pc;
      end
    end
  end

  // Stage boundary: instruction presented to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      inst_pc    <= 32'h0;
    end else begin
      if (redirect_valid) begin
        inst_valid <= 1'b0;
      end else if (capture) begin
        inst_valid <= 1'b1;
      end else if (accept) begin
        inst_valid <= 1'b0;
      end
      if (capture) begin
        inst_out <= imem_rdata;
        inst_pc  <= pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] adder_in1;
  logic [31:0] adder_in2;
  logic [31:0] adder_sum;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign_err;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .adder_in1      (adder_in1),
    .adder_in2      (adder_in2),
    .adder_sum      (adder_sum),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real adder.
  assign adder_sum = adder_in1 + adder_in2;

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Memory model: acks one cycle after it first sees a request, plus lat
  // extra cycles. force_ack injects a stray ack with garbage data.
  int   lat;
  int   wait_cnt;
  logic ack_q;
  logic force_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      wait_cnt <= 0;
    end else if (ack_q) begin
      ack_q    <= 1'b0;
      wait_cnt <= 0;
    end else if (imem_req) begin
      if (wait_cnt >= lat) ack_q <= 1'b1;
      else                 wait_cnt <= wait_cnt + 1;
    end
  end

  assign imem_ack   = ack_q | force_ack;
  assign imem_rdata = force_ack ? 32'hBAD0_BAD0 : (ack_q ? mem_word(imem_addr) : 32'hDEAD_BEEF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the program is a stream of words at consecutive
  // addresses; a redirect restarts the stream at the aligned target and
  // drops whatever had not yet been accepted.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb_q[$];
  logic        exp_mis;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          accepts = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] t;
    if (!rst_n) begin
      sb_q.delete();
      e.pc = RV; e.word = mem_word(RV);
      sb_q.push_back(e);
      exp_mis  = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (inst_valid) begin
        chk("inst_pc", inst_pc, sb_q[0].pc);
        chk("inst_out", inst_out, sb_q[0].word);
      end
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
      if (prev_req && !prev_ack) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, prev_addr);
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      if (redirect_valid) begin
        t = redirect_pc & 32'hFFFF_FFFC;
        sb_q.delete();
        e.pc = t; e.word = mem_word(t);
        sb_q.push_back(e);
        if (redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
      end else if (inst_valid && inst_ready && !stall) begin
        e = sb_q.pop_front();
        e.pc   = e.pc + 32'd4;
        e.word = mem_word(e.pc);
        sb_q.push_back(e);
        accepts++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_fetch(input string tag, output logic [31:0] addr);
    int n = 0;
    while (!(imem_req && imem_ack) && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_fetch_seen"}, 32'(imem_req && imem_ack), 32'd1);
    addr = imem_addr;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] fa[$];
    int          vc[$];
    int          acc0;

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    stall = 1'b0; inst_ready = 1'b1; lat = 0; force_ack = 1'b0;
    repeat (3) tick();

    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_adder_in1", adder_in1, RV);
    chk("rst_adder_in2", adder_in2, 32'd4);

    // Sequential fetch: addresses 0,4,8; one instruction every 3 cycles.
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (imem_req && imem_ack) fa.push_back(imem_addr);
      if (inst_valid) vc.push_back(c);
    end
    chk("seq_fetch_count", 32'(fa.size() >= 3), 32'd1);
    chk("seq_valid_count", 32'(vc.size() >= 3), 32'd1);
    if (fa.size() >= 3) begin
      chk("seq_addr0", fa[0], 32'h0);
      chk("seq_addr1", fa[1], 32'h4);
      chk("seq_addr2", fa[2], 32'h8);
    end
    if (vc.size() >= 3) begin
      chk("seq_spacing0", 32'(vc[1] - vc[0]), 32'd3);
      chk("seq_spacing1", 32'(vc[2] - vc[1]), 32'd3);
    end

    // Redirect during HOLD.
    inst_ready = 1'b0;
    wait_valid("hold_redir");
    redirect(32'h100);
    chk("hold_redir_valid_drop", 32'(inst_valid), 32'd0);
    chk("hold_redir_req", 32'(imem_req), 32'd1);
    chk("hold_redir_addr", imem_addr, 32'h100);

    // Redirect during an un-acked REQ with a slow memory: stale fetch is
    // completed at its old address, then the target is fetched.
    lat = 3;
    redirect(32'h200);
    chk("kill_req", 32'(imem_req), 32'd1);
    chk("kill_old_addr", imem_addr, 32'h100);
    chk("kill_valid", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    wait_fetch("kill_ack", a);
    chk("kill_ack_addr", a, 32'h100);
    lat = 0;
    tick();
    wait_fetch("after_kill", a);
    chk("after_kill_addr", a, 32'h200);
    wait_valid("after_kill");
    chk("after_kill_inst_pc", inst_pc, 32'h200);
    inst_ready = 1'b0;

    // Hold with decode not ready / hazard stall alternating.
    for (int i = 0; i < 5; i++) begin
      inst_ready = (i % 2 == 1);
      stall      = (i % 2 == 1);
      tick();
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst_pc", inst_pc, 32'h200);
      chk("hold_inst_out", inst_out, mem_word(32'h200));
      chk("hold_pc", adder_in1, 32'h204);
    end
    inst_ready = 1'b1; stall = 1'b0;
    tick();
    chk("resume_valid_drop", 32'(inst_valid), 32'd0);
    wait_fetch("resume", a);
    chk("resume_addr", a, 32'h204);

    // Misaligned redirect target.
    inst_ready = 1'b0;
    wait_valid("misalign");
    redirect(32'h103);
    chk("misalign_set", 32'(misalign_err), 32'd1);
    chk("misalign_addr", imem_addr, 32'h100);
    inst_ready = 1'b1;
    repeat (3) tick();
    chk("misalign_sticky", 32'(misalign_err), 32'd1);

    // PC wrap-around.
    inst_ready = 1'b0;
    wait_valid("wrap");
    redirect(32'hFFFF_FFFC);
    inst_ready = 1'b1;
    wait_fetch("wrap_top", a);
    chk("wrap_top_addr", a, 32'hFFFF_FFFC);
    tick();
    wait_fetch("wrap_zero", a);
    chk("wrap_zero_addr", a, 32'h0);
    wait_valid("wrap");
    chk("wrap_inst_pc", inst_pc, 32'h0);

    // Asynchronous reset in the middle of a fetch, then a stray late ack.
    lat = 5;
    begin
      int n = 0;
      while (!imem_req && n < 40) begin
        tick();
        n++;
      end
      chk("midreq_req_seen", 32'(imem_req), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_imem_req", 32'(imem_req), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst_out", inst_out, 32'h0);
    chk("midrst_inst_pc", inst_pc, 32'h0);
    chk("midrst_misalign", 32'(misalign_err), 32'd0);
    chk("midrst_pc", adder_in1, RV);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_ack = 1'b1;
    lat = 0;
    tick();
    force_ack = 1'b0;
    chk("late_ack_valid", 32'(inst_valid), 32'd0);
    chk("late_ack_req", 32'(imem_req), 32'd1);
    chk("late_ack_addr", imem_addr, RV);
    wait_valid("post_reset");
    chk("post_reset_inst_pc", inst_pc, RV);

    // Randomized traffic against the reference model.
    acc0 = accepts;
    for (int c = 0; c < 800; c++) begin
      lat        = $urandom_range(0, 2);
      inst_ready = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {20'h0, 12'($urandom)};
        inst_ready     = 1'b0;
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    stall = 1'b0;
    inst_ready = 1'b1;
    repeat (10) tick();
    chk("random_progress", 32'((accepts - acc0) >= 40), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
